// File: rtl/sll_iter32_pkg.sv
// Shared constants and FSM encoding for the iterative 32-bit left shifter.
package sll_iter32_pkg;

    localparam int unsigned Width     = 32;
    localparam int unsigned Shw       = 5;
    localparam int unsigned NumStages = 5;
    localparam int unsigned Kw        = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/sll_iter32_if.sv
// Operand/result handshake bundle for sll_iter32.
// in_rot exists only when SLL_ROTATE_EN is defined.
interface sll_iter32_if;
    import sll_iter32_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic [Shw-1:0]   in_shamt;
`ifdef SLL_ROTATE_EN
    logic             in_rot;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;
    logic             busy;

`ifdef SLL_ROTATE_EN
    modport master (
        output in_valid, in_data, in_shamt, in_rot, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_rot, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif

endinterface

// File: rtl/sll_stage.sv
// Combinational stage: conditionally shift or rotate a 32-bit value left by 2^k.
module sll_stage
    import sll_iter32_pkg::*;
(
    input  logic [Width-1:0] value,
    input  logic [Kw-1:0]    k,
    input  logic             en,
    input  logic             rot,
    output logic [Width-1:0] result
);

    logic [Shw-1:0]   s;
    logic [Width-1:0] shl;
    logic [Width-1:0] shr;

    always_comb begin
        s   = Shw'(1) << k;
        shl = value << s;
        // s is at most 16 here, so the wrap-around shift never reaches Width
        shr = value >> (Width - 32'(s));
        if (!en) begin
            result = value;
        end else if (rot) begin
            result = shl | shr;
        end else begin
            result = shl;
        end
    end

endmodule

// File: rtl/sll_iter32.sv
// Iterative 32-bit left shifter: one shamt bit per cycle, fixed 5-cycle latency.
// Optional rotate-left mode under SLL_ROTATE_EN.
module sll_iter32
    import sll_iter32_pkg::*;
(
    input logic          clock,
    input logic          reset_n,
    sll_iter32_if.slave  bus
);

    state_e           state_q, state_d;
    logic [Kw-1:0]    k_q, k_d;
    logic [Width-1:0] data_q, data_d;
    logic [Shw-1:0]   shamt_q, shamt_d;
    logic             rot_eff;
    logic [Width-1:0] stage_out;

`ifdef SLL_ROTATE_EN
    logic rot_q, rot_d;
    assign rot_eff = rot_q;
`else
    assign rot_eff = 1'b0;
`endif

    sll_stage u_stage (
        .value  (data_q),
        .k      (k_q),
        .en     (shamt_q[k_q]),
        .rot    (rot_eff),
        .result (stage_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        shamt_d = shamt_q;
`ifdef SLL_ROTATE_EN
        rot_d   = rot_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    shamt_d = bus.in_shamt;
`ifdef SLL_ROTATE_EN
                    rot_d   = bus.in_rot;
`endif
                    k_d     = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                data_d = stage_out;
                if (k_q == Kw'(NumStages - 1)) begin
                    k_d     = '0;
                    state_d = StDone;
                end else begin
                    k_d = k_q + Kw'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            data_q  <= '0;
            shamt_q <= '0;
`ifdef SLL_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
`ifdef SLL_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_sll_iter32.sv
// Self-checking bench for sll_iter32 with a scoreboard queue of expected results.
module tb_sll_iter32;
    import sll_iter32_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    sll_iter32_if bus ();

    sll_iter32 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                          input logic rot);
        logic [63:0] dd;
        dd = {d, d} << s;
        if (rot) return dd[63:32];
        return d << s;
    endfunction

    // Issue one operation, optionally poke in_valid during SHIFT, and hold
    // out_ready low for `hold` cycles once the result is up.
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic rot,
                         input int hold, input bit poke);
        logic        r;
        logic [31:0] first;
        logic [31:0] exp;
        int          lat;
        @(negedge clock);
        check_eq("ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_shamt  = s;
        bus.out_ready = (hold == 0);
`ifdef SLL_ROTATE_EN
        r = rot;
        bus.in_rot = rot;
`else
        r = 1'b0;
`endif
        exp_q.push_back(model(d, s, r));
        @(posedge clock);
        @(negedge clock);
        if (poke) begin
            bus.in_data  = ~d;
            bus.in_shamt = s + 5'd1;
        end else begin
            bus.in_valid = 1'b0;
        end
        lat = 0;
        while (lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (bus.out_valid) begin
                bus.in_valid = 1'b0;
                break;
            end
            check_eq("ready_busy", 32'(bus.in_ready), 32'd0);
            check_eq("busy_flag", 32'(bus.busy), 32'd1);
        end
        bus.in_valid = 1'b0;
        check_eq("latency", 32'(lat), 32'd5);
        if (!bus.out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        first = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_ready", 32'(bus.in_ready), 32'd0);
            check_eq("hold_data", bus.out_data, first);
            @(posedge clock);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        exp = exp_q.pop_front();
        check_eq("result", bus.out_data, exp);
        @(posedge clock);
        @(negedge clock);
        check_eq("idle_valid", 32'(bus.out_valid), 32'd0);
        check_eq("idle_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b0;
`ifdef SLL_ROTATE_EN
        bus.in_rot    = 1'b0;
`endif
        reset_n = 1'b0;
        #12;
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_data", bus.out_data, 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;

        do_op(32'h0000_0001, 5'd31, 1'b0, 0, 1'b0);
        do_op(32'hFFFF_FFFF, 5'd4, 1'b0, 0, 1'b0);
        do_op(32'h1234_5678, 5'd8, 1'b0, 0, 1'b0);
        do_op(32'hDEAD_BEEF, 5'd0, 1'b0, 0, 1'b1);
        do_op(32'hA5A5_3C3C, 5'd13, 1'b0, 3, 1'b0);

        // Reset while in SHIFT with k==2: transaction is dropped.
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE_F00D;
        bus.in_shamt = 5'd7;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_data", bus.out_data, 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        do_op(32'h0F0F_00FF, 5'd3, 1'b0, 0, 1'b0);

`ifdef SLL_ROTATE_EN
        do_op(32'h8000_0001, 5'd1, 1'b1, 0, 1'b0);
        do_op(32'h8000_0001, 5'd1, 1'b0, 0, 1'b0);
        do_op(32'hF000_000F, 5'd20, 1'b1, 1, 1'b0);
`endif

        for (int n = 0; n < 10; n++) begin
            do_op($urandom, 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        end

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
